// File: rtl/lifo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lifo_pkg
// Description : Shared constants, operation decode and sizing helpers for the
//               LIFO stack.
// Revision    : 1.0 - initial release
// ============================================================================
package lifo_pkg;

    localparam int LIFO_DEFAULT_WIDTH = 12;
    localparam int LIFO_DEFAULT_DEPTH = 8;

    // One operation is selected per edge.
    typedef enum logic [2:0] {
        OP_IDLE    = 3'd0,
        OP_FLUSH   = 3'd1,
        OP_REPLACE = 3'd2,
        OP_PUSH    = 3'd3,
        OP_POP     = 3'd4
    } op_e;

    // Count must represent 0..DEPTH inclusive, so it needs one more code
    // than the pointer.
    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Fixed priority: flush, then simultaneous push/pop, then push, then pop.
    function automatic op_e decode_op(input logic f_flush,
                                      input logic f_push,
                                      input logic f_pop);
        if (f_flush)
            return OP_FLUSH;
        else if (f_push && f_pop)
            return OP_REPLACE;
        else if (f_push)
            return OP_PUSH;
        else if (f_pop)
            return OP_POP;
        else
            return OP_IDLE;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lifo_mem.sv
`default_nettype none
// ============================================================================
// Module      : lifo_mem
// Description : Storage array for the LIFO stack. One synchronous write
//               port, one combinational read port, no reset.
// Revision    : 1.0 - initial release
// ============================================================================
module lifo_mem #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    // Contents are only ever observed below count, so no reset is required.
    always_ff @(posedge clk) begin
        if (we)
            r_mem[waddr] <= wdata;
    end

    assign rdata = r_mem[raddr];

endmodule
`default_nettype wire

// File: rtl/lifo_stack.sv
`default_nettype none
// ============================================================================
// Module      : lifo_stack
// Description : Parameterised LIFO stack with registered top-of-stack
//               output, flush, push/pop replace and one-cycle overflow /
//               underflow error pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module lifo_stack
    import lifo_pkg::*;
#(
    parameter int WIDTH = LIFO_DEFAULT_WIDTH,
    parameter int DEPTH = LIFO_DEFAULT_DEPTH
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          push,
    input  logic                          pop,
    input  logic                          flush,
    input  logic [WIDTH-1:0]              data_in,
    output logic [WIDTH-1:0]              data_out,
    output logic [count_width(DEPTH)-1:0] count,
    output logic                          empty,
    output logic                          full,
    output logic                          overflow,
    output logic                          underflow
);

    localparam int c_cnt_w = count_width(DEPTH);
    localparam int c_ptr_w = $clog2(DEPTH);

    localparam logic [c_cnt_w-1:0] c_one   = c_cnt_w'(1);
    localparam logic [c_cnt_w-1:0] c_two   = c_cnt_w'(2);
    localparam logic [c_cnt_w-1:0] c_depth = c_cnt_w'(DEPTH);

    logic [c_cnt_w-1:0] r_count;
    logic [WIDTH-1:0]   r_data;
    logic               r_ovf;
    logic               r_udf;

    logic [c_cnt_w-1:0] w_next_count;
    logic [WIDTH-1:0]   w_next_data;
    logic               w_next_ovf;
    logic               w_next_udf;
    logic               w_we;
    logic [c_ptr_w-1:0] w_waddr;
    logic [c_ptr_w-1:0] w_raddr;
    logic [WIDTH-1:0]   w_rdata;
    logic               w_is_empty;
    logic               w_is_full;
    op_e                w_op;

    assign w_is_empty = (r_count == '0);
    assign w_is_full  = (r_count == c_depth);
    assign w_op       = decode_op(flush, push, pop);

    // After a pop the new top lives at index count-2; only used when count>=2.
    assign w_raddr = c_ptr_w'(r_count - c_two);

    lifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (w_we),
        .waddr (w_waddr),
        .wdata (data_in),
        .raddr (w_raddr),
        .rdata (w_rdata)
    );

    // Next-state decode: storage write, count, top-of-stack value and errors.
    always_comb begin
        w_next_count = r_count;
        w_next_data  = r_data;
        w_next_ovf   = 1'b0;
        w_next_udf   = 1'b0;
        w_we         = 1'b0;
        w_waddr      = c_ptr_w'(r_count);
        case (w_op)
            OP_FLUSH: begin
                w_next_count = '0;
                w_next_data  = '0;
            end
            OP_REPLACE: begin
                w_we        = 1'b1;
                w_next_data = data_in;
                if (w_is_empty) begin
                    // Nothing to replace: degrade to a push at index 0.
                    w_next_count = c_one;
                    w_next_udf   = 1'b1;
                end else begin
                    w_waddr = c_ptr_w'(r_count - c_one);
                end
            end
            OP_PUSH: begin
                if (w_is_full) begin
                    w_next_ovf = 1'b1;
                end else begin
                    w_we         = 1'b1;
                    w_next_count = r_count + c_one;
                    w_next_data  = data_in;
                end
            end
            OP_POP: begin
                if (w_is_empty) begin
                    w_next_udf = 1'b1;
                end else begin
                    w_next_count = r_count - c_one;
                    w_next_data  = (r_count == c_one) ? '0 : w_rdata;
                end
            end
            default: begin
                w_next_count = r_count;
            end
        endcase
    end

    // State and registered outputs; reset clears everything immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
            r_data  <= '0;
            r_ovf   <= 1'b0;
            r_udf   <= 1'b0;
        end else begin
            r_count <= w_next_count;
            r_data  <= w_next_data;
            r_ovf   <= w_next_ovf;
            r_udf   <= w_next_udf;
        end
    end

    assign data_out  = r_data;
    assign count     = r_count;
    assign empty     = w_is_empty;
    assign full      = w_is_full;
    assign overflow  = r_ovf;
    assign underflow = r_udf;

endmodule
`default_nettype wire

// File: tb/tb_lifo_stack.sv
`default_nettype none
// ============================================================================
// Module      : tb_lifo_stack
// Description : Self-checking bench for lifo_stack: directed scenarios plus
//               randomized traffic against a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lifo_stack;

    localparam int W  = 12;
    localparam int D  = 8;
    localparam int CW = $clog2(D + 1);

    logic          clk;
    logic          rst_n;
    logic          push;
    logic          pop;
    logic          flush;
    logic [W-1:0]  data_in;
    logic [W-1:0]  data_out;
    logic [CW-1:0] count;
    logic          empty;
    logic          full;
    logic          overflow;
    logic          underflow;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: the stack is a queue, top at the back.
    logic [W-1:0] mq[$];
    logic         m_ovf;
    logic         m_udf;

    lifo_stack #(
        .WIDTH (W),
        .DEPTH (D)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .pop       (pop),
        .flush     (flush),
        .data_in   (data_in),
        .data_out  (data_out),
        .count     (count),
        .empty     (empty),
        .full      (full),
        .overflow  (overflow),
        .underflow (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W-1:0] exp_data();
        return (mq.size() == 0) ? '0 : mq[$];
    endfunction

    function automatic logic [CW-1:0] exp_count();
        return CW'(mq.size());
    endfunction

    // Apply one operation across one rising edge and advance the model.
    // Returns at edge+1, where outputs are stable for checking.
    task automatic step(input logic p, input logic po, input logic f,
                        input logic [W-1:0] d);
        push    = p;
        pop     = po;
        flush   = f;
        data_in = d;
        @(posedge clk);
        #1;
        m_ovf = 1'b0;
        m_udf = 1'b0;
        if (f) begin
            mq.delete();
        end else if (p && po) begin
            if (mq.size() == 0) begin
                mq.push_back(d);
                m_udf = 1'b1;
            end else begin
                mq[mq.size()-1] = d;
            end
        end else if (p) begin
            if (mq.size() == D) m_ovf = 1'b1;
            else mq.push_back(d);
        end else if (po) begin
            if (mq.size() == 0) m_udf = 1'b1;
            else void'(mq.pop_back());
        end
        push    = 1'b0;
        pop     = 1'b0;
        flush   = 1'b0;
        data_in = '0;
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        push    = 1'b0;
        pop     = 1'b0;
        flush   = 1'b0;
        data_in = '0;
        mq.delete();
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if ({count, data_out, empty, full, overflow, underflow} !==
            {CW'(0), W'(0), 1'b1, 1'b0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset: count=%0d data_out=%0d empty=%b full=%b ovf=%b udf=%b, want 0 0 1 0 0 0",
                     count, data_out, empty, full, overflow, underflow);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        step(1'b1, 1'b0, 1'b0, W'(31));
        step(1'b1, 1'b0, 1'b0, W'(1023));
        n_tests++;
        if (count !== CW'(2) || data_out !== W'(1023)) begin
            n_fail++;
            $display("FAIL basic_push2: count=%0d data_out=%0d, want 2 1023", count, data_out);
        end
        step(1'b0, 1'b1, 1'b0, '0);
        n_tests++;
        if (count !== CW'(1) || data_out !== W'(31)) begin
            n_fail++;
            $display("FAIL basic_pop1: count=%0d data_out=%0d, want 1 31", count, data_out);
        end
        step(1'b0, 1'b1, 1'b0, '0);
        n_tests++;
        if (empty !== 1'b1 || data_out !== W'(0) || count !== CW'(0)) begin
            n_fail++;
            $display("FAIL basic_pop2: empty=%b data_out=%0d count=%0d, want 1 0 0", empty, data_out, count);
        end
    endtask

    task automatic test_overflow();
        step(1'b0, 1'b0, 1'b1, '0);
        for (int i = 1; i <= D; i++) step(1'b1, 1'b0, 1'b0, W'(i));
        n_tests++;
        if (full !== 1'b1 || count !== CW'(D) || data_out !== W'(D)) begin
            n_fail++;
            $display("FAIL fill: full=%b count=%0d data_out=%0d, want 1 %0d %0d", full, count, data_out, D, D);
        end
        step(1'b1, 1'b0, 1'b0, W'(9));
        n_tests++;
        if (overflow !== 1'b1 || underflow !== 1'b0 || data_out !== W'(8) || count !== CW'(8)) begin
            n_fail++;
            $display("FAIL overflow: ovf=%b udf=%b data_out=%0d count=%0d, want 1 0 8 8",
                     overflow, underflow, data_out, count);
        end
        step(1'b0, 1'b0, 1'b0, '0);
        n_tests++;
        if (overflow !== 1'b0 || data_out !== W'(8)) begin
            n_fail++;
            $display("FAIL overflow_pulse_end: ovf=%b data_out=%0d, want 0 8", overflow, data_out);
        end
    endtask

    task automatic test_underflow();
        step(1'b0, 1'b0, 1'b1, '0);
        step(1'b0, 1'b1, 1'b0, '0);
        n_tests++;
        if (underflow !== 1'b1 || count !== CW'(0) || data_out !== W'(0)) begin
            n_fail++;
            $display("FAIL underflow_pop: udf=%b count=%0d data_out=%0d, want 1 0 0", underflow, count, data_out);
        end
        step(1'b1, 1'b1, 1'b0, W'(5));
        n_tests++;
        if (underflow !== 1'b1 || count !== CW'(1) || data_out !== W'(5)) begin
            n_fail++;
            $display("FAIL underflow_pushpop: udf=%b count=%0d data_out=%0d, want 1 1 5", underflow, count, data_out);
        end
        step(1'b0, 1'b0, 1'b0, '0);
        n_tests++;
        if (underflow !== 1'b0 || count !== CW'(1)) begin
            n_fail++;
            $display("FAIL underflow_pulse_end: udf=%b count=%0d, want 0 1", underflow, count);
        end
    endtask

    task automatic test_replace_full();
        step(1'b0, 1'b0, 1'b1, '0);
        for (int i = 1; i <= D; i++) step(1'b1, 1'b0, 1'b0, W'(i));
        step(1'b1, 1'b1, 1'b0, W'(77));
        n_tests++;
        if (count !== CW'(8) || data_out !== W'(77) || overflow !== 1'b0 || underflow !== 1'b0) begin
            n_fail++;
            $display("FAIL replace_full: count=%0d data_out=%0d ovf=%b udf=%b, want 8 77 0 0",
                     count, data_out, overflow, underflow);
        end
        for (int i = D - 1; i >= 0; i--) begin
            step(1'b0, 1'b1, 1'b0, '0);
            n_tests++;
            if (data_out !== W'(i) || count !== CW'(i)) begin
                n_fail++;
                $display("FAIL drain_%0d: data_out=%0d count=%0d, want %0d %0d", i, data_out, count, i, i);
            end
        end
    endtask

    task automatic test_flush();
        step(1'b0, 1'b0, 1'b1, '0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, W'(100 + i));
        step(1'b1, 1'b0, 1'b1, W'(55));
        n_tests++;
        if (count !== CW'(0) || empty !== 1'b1 || data_out !== W'(0) ||
            overflow !== 1'b0 || underflow !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_push: count=%0d empty=%b data_out=%0d ovf=%b udf=%b, want 0 1 0 0 0",
                     count, empty, data_out, overflow, underflow);
        end
    endtask

    task automatic test_async_reset();
        step(1'b0, 1'b0, 1'b1, '0);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, W'(200 + i));
        // Mid-cycle: start an operation, then drop reset well before the edge.
        push    = 1'b1;
        data_in = W'(333);
        #2;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (count !== CW'(0) || data_out !== W'(0) || empty !== 1'b1 || full !== 1'b0 ||
            overflow !== 1'b0 || underflow !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: count=%0d data_out=%0d empty=%b full=%b ovf=%b udf=%b, want 0 0 1 0 0 0",
                     count, data_out, empty, full, overflow, underflow);
        end
        push = 1'b0;
        #2;
        rst_n = 1'b1;
        mq.delete();
        step(1'b1, 1'b0, 1'b0, W'(9));
        n_tests++;
        if (count !== CW'(1) || data_out !== W'(9)) begin
            n_fail++;
            $display("FAIL after_reset_push: count=%0d data_out=%0d, want 1 9", count, data_out);
        end
    endtask

    task automatic test_random();
        logic         p, po, f;
        logic [W-1:0] d;
        int           r;
        logic         e_empty, e_full;
        step(1'b0, 1'b0, 1'b1, '0);
        for (int i = 0; i < 400; i++) begin
            r  = int'($urandom_range(0, 99));
            f  = (r < 3);
            p  = ($urandom_range(0, 99) < 55);
            po = ($urandom_range(0, 99) < 45);
            d  = W'($urandom);
            step(p, po, f, d);
            e_empty = (mq.size() == 0);
            e_full  = (mq.size() == D);
            n_tests++;
            if ({count, data_out, empty, full, overflow, underflow} !==
                {exp_count(), exp_data(), e_empty, e_full, m_ovf, m_udf}) begin
                n_fail++;
                $display("FAIL random_%0d: count=%0d data_out=%0d e=%b f=%b ovf=%b udf=%b, want %0d %0d %b %b %b %b",
                         i, count, data_out, empty, full, overflow, underflow,
                         exp_count(), exp_data(), e_empty, e_full, m_ovf, m_udf);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_underflow();
        test_replace_full();
        test_flush();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/lifo_stack.md
LIFO_STACK -- requirements
Module: lifo_stack

Interface
REQ-001 The block SHALL have parameter WIDTH, default 12, meaning data word width in bits (>=1).
REQ-002 The block SHALL have parameter DEPTH, default 8, meaning entry count (power of two, >=2).
REQ-003 The block SHALL have port clk, input, 1, meaning the single clock; all state updates on the rising edge.
REQ-004 The block SHALL have port rst_n, input, 1, meaning asynchronous active-low reset.
REQ-005 The block SHALL have port push, input, 1, meaning write data_in as the new top entry.
REQ-006 The block SHALL have port pop, input, 1, meaning discard the top entry.
REQ-007 The block SHALL have port flush, input, 1, meaning synchronous clear of all entries.
REQ-008 The block SHALL have port data_in, input, WIDTH, meaning the word to push.
REQ-009 The block SHALL have port data_out, output, WIDTH, meaning the current top entry (registered).
REQ-010 The block SHALL have port count, output, $clog2(DEPTH+1), meaning the number of valid entries.
REQ-011 The block SHALL have ports empty and full, output, 1 each, meaning count==0 and count==DEPTH respectively.
REQ-012 The block SHALL have ports overflow and underflow, output, 1 each, meaning one-cycle error pulses.

Function
REQ-013 Operation priority SHALL be flush > (push&pop) > push > pop, evaluated per rising edge.
REQ-014 On flush, count SHALL become 0, data_out SHALL become 0, error pulses SHALL be 0, and push/pop SHALL be ignored.
REQ-015 On push only and not full, the block SHALL store data_in at index count, increment count, and set data_out=data_in on the same edge.
REQ-016 On pop only and not empty, the block SHALL decrement count and set data_out to the entry at index count-2, or to 0 if the stack becomes empty.
REQ-017 On push&pop and not empty, the block SHALL replace the top entry with data_in, leave count unchanged, and set data_out=data_in; this SHALL also be legal when full.
REQ-018 On push&pop when empty, the block SHALL perform a plain push and pulse underflow for one cycle.
REQ-019 On push only when full, the block SHALL leave storage, count and data_out unchanged and pulse overflow for one cycle.
REQ-020 On pop only when empty, the block SHALL leave state unchanged and pulse underflow for one cycle.
REQ-021 The overflow and underflow outputs SHALL be registered, high exactly in the cycle following the offending edge, and 0 otherwise.
REQ-022 The data_out output SHALL always be 0 when empty is 1; storage contents beyond count SHALL never reach data_out.
REQ-023 The count output SHALL never exceed DEPTH and SHALL never wrap below 0.

Reset
REQ-024 While rst_n is low, the block SHALL immediately force count=0, data_out=0, overflow=0 and underflow=0, so that empty=1 and full=0.
REQ-025 Storage array contents SHALL NOT need a reset value, since they are unobservable while empty.
REQ-026 Assertion of rst_n mid-operation SHALL abandon any in-flight push or pop; the first edge after deassertion SHALL behave as if the block were empty.

Structure
REQ-027 Package lifo_pkg SHALL hold default WIDTH/DEPTH constants and a helper function returning the count width.
REQ-028 The storage array SHALL be a sub-module lifo_mem (1 write port, 1 combinational read port, no reset), instantiated once.
REQ-029 Pointer, count and flag logic SHALL reside in lifo_stack; the data_out register SHALL be loaded from the next-state top value, not from a delayed read.

Verification
REQ-030 The bench SHALL cover: reset then push 31 and 1023 -> count=2, data_out=1023; pop -> data_out=31, count=1; pop -> empty=1, data_out=0.
REQ-031 The bench SHALL cover: push 1..8 (DEPTH=8) -> full=1; push 9 -> overflow pulse, data_out=8, count=8.
REQ-032 The bench SHALL cover: empty, pop -> underflow pulse, count=0; empty with push&pop and data_in=5 -> count=1, data_out=5, underflow pulse.
REQ-033 The bench SHALL cover: full with push&pop and data_in=77 -> count=8, data_out=77; then 8 pops -> data_out sequence 7,6,...,1,0.
REQ-034 The bench SHALL cover: stack holding 3 entries, flush asserted together with push -> count=0, empty=1, no error pulse.
REQ-035 The bench SHALL cover: rst_n dropped between edges with count=4 -> outputs cleared without waiting for a clock edge; next push of 9 -> count=1, data_out=9.
